control_minero: RTL and testbench
=================================

Name: control_minero

Overview:
- Nonce-search controller on the DUT side of the mining interface; it is the responder to the bench stimulus (num_entradas, target).
- Iterates candidate nonces and requests a 24-bit hash for each from the hash core over a req/valid handshake.
- Qualifies each hash against target and reports every qualifying nonce on nonce_valido_out / bounty_out.
- Raises fin when num_entradas hits are found or the nonce space is exhausted.

Parameters:
NONCE_INICIO, 32'h0000_0000, first nonce tried
NONCE_MAX, 32'hFFFF_FFFF, last nonce tried (inclusive)

Ports:
clk  input  1  single clock, all logic on rising edge
reset_L  input  1  asynchronous, active-low reset
inicio  input  1  start pulse; sampled only in IDLE or DONE
num_entradas  input  2  hits required before fin; 2'd0 encodes 4
target  input  8  hit when hash_in[23:16] < target (unsigned)
hash_req  output  1  one-cycle request pulse to hash core
hash_nonce  output  32  nonce for current request, stable from hash_req until hash_valid
hash_valid  input  1  hash core result strobe
hash_in  input  24  hash result, valid with hash_valid
nonce_valido_out  output  32  last qualifying nonce
bounty_out  output  24  hash of last qualifying nonce
valido  output  1  one-cycle pulse when nonce_valido_out/bounty_out update
fin  output  1  search finished; held until next inicio
agotado  output  1  with fin: nonce space exhausted before num_entradas hits

Behaviour:
- Reset (reset_L=0, async): state IDLE; all outputs 0; internal nonce = NONCE_INICIO; hit count = 0.
- Reset mid-search: immediate abort, same values as reset; any in-flight hash_valid after release is ignored.
- IDLE: on inicio, latch target and num_entradas (later input changes ignored until next start), nonce<=NONCE_INICIO, count<=0, clear fin/agotado; go REQ.
- REQ (1 cycle): hash_req=1, hash_nonce=nonce; go WAIT.
- WAIT: hold hash_nonce; stay until hash_valid; then register hash_in and go CHECK. No timeout.
- hash_valid outside WAIT: ignored.
- CHECK (1 cycle), hit when hash_in[23:16] < latched target:
  - Hit: nonce_valido_out<=nonce, bounty_out<=hash_in, valido pulses next cycle, count+1.
  - Hit with count+1 == required (1..4): go DONE, fin=1, agotado=0.
  - Else nonce == NONCE_MAX: go DONE, fin=1, agotado=1. A hit on NONCE_MAX that also satisfies the count gives agotado=0.
  - Else nonce+1, go REQ. No wrap; the NONCE_MAX check precedes the increment.
- DONE: fin and agotado held; nonce_valido_out/bounty_out hold the last hit. inicio restarts exactly as from IDLE (fin drops the cycle after inicio).
- inicio in REQ/WAIT/CHECK: ignored.
- target=0: no hit possible; runs to exhaustion.
- Throughput: one nonce per (hash latency + 2) cycles. Minimum fin latency after the final hash_valid: 2 cycles.
- Width rules:
  - Count is 3 bits.
  - Required count = {num_entradas==0, num_entradas}.
  - Comparison is unsigned 8-bit.

Decomposition:
- Shared package: FSM state encoding (IDLE, REQ, WAIT, CHECK, DONE), HASH_W=24, NONCE_W=32, TARGET_W=8, num_entradas decode function.
- One sub-module is natural: comparador_target (registered hash/target compare plus hit-count logic), instantiated once.
- FSM and nonce counter stay in control_minero.

Test Plan:
- Bench hash model: hash_in = {nonce[7:0]^8'hA5, 16'h1234}, 3-cycle latency.
1. target=8'h10, num_entradas=2, inicio -> valido twice:
   - nonce_valido_out=32'hA0 with bounty_out=24'h051234
   - then 32'hA1 with 24'h041234
   - then fin=1, agotado=0, no hash_req after nonce A1.
2. NONCE_MAX=32'h3F, target=8'h10, num_entradas=1 -> no valido; exactly 64 hash_req; fin=1, agotado=1; nonce_valido_out=0.
3. num_entradas=0, target=8'h10 -> four hits (A0..A3) then fin; fourth bounty_out=24'h061234.
4. Assert reset_L=0 while in WAIT at nonce 5 -> outputs 0 asynchronously; after release, a late hash_valid is ignored; next inicio restarts at nonce 0.
5. Pulse inicio during WAIT, and change target mid-search -> no restart; results match scenario 1.
6. target=8'hFF, num_entradas=1 -> first nonce 0 hits (0^A5=A5<FF); fin 2 cycles after first hash_valid; then inicio again -> fin drops the next cycle, search repeats.

Source files
------------

// File: rtl/control_minero_pkg.sv
// Shared definitions for the nonce-search controller.
//   - estado_t         : FSM state encoding
//   - HASH_W/NONCE_W/TARGET_W/COUNT_W : datapath widths
//   - decode_entradas(): maps the 2-bit num_entradas code to a hit count 1..4
package control_minero_pkg;

  localparam int HASH_W   = 24;
  localparam int NONCE_W  = 32;
  localparam int TARGET_W = 8;
  localparam int COUNT_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } estado_t;

  // 2'd0 encodes four hits; the extra MSB makes that value fit in COUNT_W.
  function automatic logic [COUNT_W-1:0] decode_entradas(input logic [1:0] n);
    return {(n == 2'd0), n};
  endfunction

endpackage

// File: rtl/control_minero_comparador_target.sv
// Registered hash/target comparison and hit counter.
// Ports:
//   clk, reset_L       : clock, async active-low reset
//   i_start            : latch target / required hit count, clear the counter
//   i_capture          : register i_hash (result strobe accepted by the FSM)
//   i_check            : FSM is in CHECK; a hit advances the counter
//   i_hash             : hash result from the core
//   i_target           : threshold, latched on i_start
//   i_num_entradas     : required-hits code, latched on i_start
//   o_hash             : registered hash under evaluation
//   o_hit              : registered hash qualifies against latched target
//   o_last_hit         : this hit is the one that completes the required count
module comparador_target
  import control_minero_pkg::*;
(
  input  logic                clk,
  input  logic                reset_L,
  input  logic                i_start,
  input  logic                i_capture,
  input  logic                i_check,
  input  logic [HASH_W-1:0]   i_hash,
  input  logic [TARGET_W-1:0] i_target,
  input  logic [1:0]          i_num_entradas,
  output logic [HASH_W-1:0]   o_hash,
  output logic                o_hit,
  output logic                o_last_hit
);

  logic [TARGET_W-1:0] r_target;
  logic [COUNT_W-1:0]  r_required;
  logic [COUNT_W-1:0]  r_count;
  logic [HASH_W-1:0]   r_hash;
  logic                w_hit;

  // Unsigned compare on the top byte of the hash.
  assign w_hit      = (r_hash[HASH_W-1 -: TARGET_W] < r_target);
  assign o_hit      = w_hit;
  assign o_last_hit = w_hit && ((r_count + COUNT_W'(1)) == r_required);
  assign o_hash     = r_hash;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_target   <= '0;
      r_required <= '0;
      r_count    <= '0;
      r_hash     <= '0;
    end else begin
      if (i_start) begin
        r_target   <= i_target;
        r_required <= decode_entradas(i_num_entradas);
        r_count    <= '0;
      end else if (i_check && w_hit) begin
        r_count <= r_count + COUNT_W'(1);
      end
      if (i_capture) r_hash <= i_hash;
    end
  end

endmodule

// File: rtl/control_minero.sv
// Nonce-search controller. Walks nonces NONCE_INICIO..NONCE_MAX, requests a
// hash per nonce, reports qualifying nonces and stops after the required
// number of hits or when the nonce space is exhausted.
// Ports:
//   clk, reset_L               : clock, async active-low reset
//   inicio                     : start pulse (honoured in IDLE/DONE only)
//   num_entradas, target       : search parameters, latched at start
//   hash_req, hash_nonce       : request pulse and nonce to the hash core
//   hash_valid, hash_in        : result strobe and hash from the core
//   nonce_valido_out, bounty_out, valido : last hit and its update pulse
//   fin, agotado               : search finished / finished by exhaustion
module control_minero
  import control_minero_pkg::*;
#(
  parameter logic [NONCE_W-1:0] NONCE_INICIO = 32'h0000_0000,
  parameter logic [NONCE_W-1:0] NONCE_MAX    = 32'hFFFF_FFFF
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic                inicio,
  input  logic [1:0]          num_entradas,
  input  logic [TARGET_W-1:0] target,
  output logic                hash_req,
  output logic [NONCE_W-1:0]  hash_nonce,
  input  logic                hash_valid,
  input  logic [HASH_W-1:0]   hash_in,
  output logic [NONCE_W-1:0]  nonce_valido_out,
  output logic [HASH_W-1:0]   bounty_out,
  output logic                valido,
  output logic                fin,
  output logic                agotado
);

  estado_t             r_estado, w_siguiente;
  logic [NONCE_W-1:0]  r_nonce;
  logic [NONCE_W-1:0]  r_nonce_valido;
  logic [HASH_W-1:0]   r_bounty;
  logic                r_valido, r_fin, r_agotado;
  logic                w_start, w_capture, w_check;
  logic                w_hit, w_last_hit;
  logic [HASH_W-1:0]   w_hash;

  comparador_target u_comparador (
    .clk            (clk),
    .reset_L        (reset_L),
    .i_start        (w_start),
    .i_capture      (w_capture),
    .i_check        (w_check),
    .i_hash         (hash_in),
    .i_target       (target),
    .i_num_entradas (num_entradas),
    .o_hash         (w_hash),
    .o_hit          (w_hit),
    .o_last_hit     (w_last_hit)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) r_estado <= ST_IDLE;
    else          r_estado <= w_siguiente;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_siguiente = r_estado;
    w_start     = 1'b0;
    w_capture   = 1'b0;
    w_check     = 1'b0;
    case (r_estado)
      ST_IDLE, ST_DONE: begin
        if (inicio) begin
          w_start     = 1'b1;
          w_siguiente = ST_REQ;
        end
      end
      ST_REQ:  w_siguiente = ST_WAIT;
      ST_WAIT: begin
        if (hash_valid) begin
          w_capture   = 1'b1;
          w_siguiente = ST_CHECK;
        end
      end
      ST_CHECK: begin
        w_check = 1'b1;
        // Completing the hit count wins over exhaustion on NONCE_MAX.
        if (w_last_hit || (r_nonce == NONCE_MAX)) w_siguiente = ST_DONE;
        else                                     w_siguiente = ST_REQ;
      end
      default: w_siguiente = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_nonce        <= NONCE_INICIO;
      r_nonce_valido <= '0;
      r_bounty       <= '0;
      r_valido       <= 1'b0;
      r_fin          <= 1'b0;
      r_agotado      <= 1'b0;
    end else begin
      r_valido <= w_check && w_hit;
      if (w_start) begin
        r_nonce   <= NONCE_INICIO;
        r_fin     <= 1'b0;
        r_agotado <= 1'b0;
      end else if (w_check) begin
        if (w_hit) begin
          r_nonce_valido <= r_nonce;
          r_bounty       <= w_hash;
        end
        if (w_siguiente == ST_DONE) begin
          r_fin     <= 1'b1;
          r_agotado <= !w_last_hit;
        end else begin
          r_nonce <= r_nonce + NONCE_W'(1);
        end
      end
    end
  end

  assign hash_req         = (r_estado == ST_REQ);
  assign hash_nonce       = r_nonce;
  assign nonce_valido_out = r_nonce_valido;
  assign bounty_out       = r_bounty;
  assign valido           = r_valido;
  assign fin              = r_fin;
  assign agotado          = r_agotado;

endmodule

// File: tb/tb_control_minero.sv
// Directed bench for control_minero. A 3-cycle hash model answers each
// request with {nonce[7:0]^8'hA5, 16'h1234}. A second instance with
// NONCE_MAX=32'h3F covers exhaustion.
module tb_control_minero;

  logic        clk = 1'b0;
  logic        reset_L;
  logic        inicio, inicio_s;
  logic [1:0]  num_entradas;
  logic [7:0]  target;

  logic        hash_req, hash_valid, valido, fin, agotado;
  logic [31:0] hash_nonce, nonce_valido_out;
  logic [23:0] hash_in, bounty_out;

  logic        hash_req_s, hash_valid_s, valido_s, fin_s, agotado_s;
  logic [31:0] hash_nonce_s, nonce_valido_out_s;
  logic [23:0] hash_in_s, bounty_out_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  control_minero dut (
    .clk(clk), .reset_L(reset_L), .inicio(inicio), .num_entradas(num_entradas),
    .target(target), .hash_req(hash_req), .hash_nonce(hash_nonce),
    .hash_valid(hash_valid), .hash_in(hash_in),
    .nonce_valido_out(nonce_valido_out), .bounty_out(bounty_out),
    .valido(valido), .fin(fin), .agotado(agotado));

  control_minero #(.NONCE_MAX(32'h3F)) dut_s (
    .clk(clk), .reset_L(reset_L), .inicio(inicio_s), .num_entradas(num_entradas),
    .target(target), .hash_req(hash_req_s), .hash_nonce(hash_nonce_s),
    .hash_valid(hash_valid_s), .hash_in(hash_in_s),
    .nonce_valido_out(nonce_valido_out_s), .bounty_out(bounty_out_s),
    .valido(valido_s), .fin(fin_s), .agotado(agotado_s));

  // Hash models: 3-cycle latency, not affected by DUT reset.
  logic [2:0]  hv_p = '0,  hv_ps = '0;
  logic [31:0] hn0 = '0, hn1 = '0, hn2 = '0;
  logic [31:0] hs0 = '0, hs1 = '0, hs2 = '0;
  always @(posedge clk) begin
    hv_p  <= {hv_p[1:0], hash_req};
    hn0 <= hash_nonce; hn1 <= hn0; hn2 <= hn1;
    hv_ps <= {hv_ps[1:0], hash_req_s};
    hs0 <= hash_nonce_s; hs1 <= hs0; hs2 <= hs1;
  end
  assign hash_valid   = hv_p[2];
  assign hash_in      = {hn2[7:0] ^ 8'hA5, 16'h1234};
  assign hash_valid_s = hv_ps[2];
  assign hash_in_s    = {hs2[7:0] ^ 8'hA5, 16'h1234};

  // Event monitor, sampled on the falling edge.
  int          req_cnt, req_cnt_s, val_cnt_s;
  logic [31:0] last_req_nonce;
  logic [31:0] vq_nonce[$];
  logic [23:0] vq_bounty[$];
  always @(negedge clk) begin
    if (hash_req) begin
      req_cnt++;
      last_req_nonce = hash_nonce;
    end
    if (valido) begin
      vq_nonce.push_back(nonce_valido_out);
      vq_bounty.push_back(bounty_out);
    end
    if (hash_req_s) req_cnt_s++;
    if (valido_s)   val_cnt_s++;
  end

  task automatic clear_mon();
    req_cnt = 0; req_cnt_s = 0; val_cnt_s = 0; last_req_nonce = '0;
    vq_nonce.delete(); vq_bounty.delete();
  endtask

  task automatic pulse_inicio();
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
  endtask

  task automatic wait_fin(input string name, input int budget);
    int k = 0;
    while (!fin && k < budget) begin @(negedge clk); k++; end
    n_tests++;
    if (!fin) begin n_fail++; $display("FAIL %s_timeout: fin=%b required 1", name, fin); end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_L = 1'b0;
    @(negedge clk);
    reset_L = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_L = 1'b0; inicio = 0; inicio_s = 0; num_entradas = 0; target = 0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({hash_req, hash_nonce, nonce_valido_out, bounty_out, valido, fin, agotado} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: req=%b nonce=%h nv=%h b=%h v=%b fin=%b ag=%b required all 0",
        hash_req, hash_nonce, nonce_valido_out, bounty_out, valido, fin, agotado);
    end
    reset_L = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (hash_req !== 1'b0 || fin !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_start: req=%b fin=%b required 0 0", hash_req, fin);
    end
  endtask

  task automatic test_two_hits();
    clear_mon();
    target = 8'h10; num_entradas = 2'd2;
    pulse_inicio();
    wait_fin("two_hits", 2000);
    n_tests++;
    if (vq_nonce.size() != 2) begin
      n_fail++; $display("FAIL two_hits_count: got %0d valido pulses required 2", vq_nonce.size());
    end else begin
      n_tests++;
      if (vq_nonce[0] !== 32'hA0 || vq_bounty[0] !== 24'h051234) begin
        n_fail++; $display("FAIL two_hits_first: got %h/%h required a0/051234", vq_nonce[0], vq_bounty[0]);
      end
      n_tests++;
      if (vq_nonce[1] !== 32'hA1 || vq_bounty[1] !== 24'h041234) begin
        n_fail++; $display("FAIL two_hits_second: got %h/%h required a1/041234", vq_nonce[1], vq_bounty[1]);
      end
    end
    n_tests++;
    if (agotado !== 1'b0) begin n_fail++; $display("FAIL two_hits_agotado: got %b required 0", agotado); end
    repeat (10) @(negedge clk);
    n_tests++;
    if (req_cnt != 162 || last_req_nonce !== 32'hA1) begin
      n_fail++; $display("FAIL two_hits_reqs: got %0d reqs last %h required 162 last a1", req_cnt, last_req_nonce);
    end
    n_tests++;
    if (fin !== 1'b1 || nonce_valido_out !== 32'hA1) begin
      n_fail++; $display("FAIL two_hits_hold: fin=%b nv=%h required 1 a1", fin, nonce_valido_out);
    end
  endtask

  task automatic test_exhaustion();
    int k = 0;
    clear_mon();
    target = 8'h10; num_entradas = 2'd1;
    inicio_s = 1'b1; @(negedge clk); inicio_s = 1'b0;
    while (!fin_s && k < 500) begin @(negedge clk); k++; end
    @(negedge clk);
    n_tests++;
    if (fin_s !== 1'b1 || agotado_s !== 1'b1) begin
      n_fail++; $display("FAIL exhaust_flags: fin=%b agotado=%b required 1 1", fin_s, agotado_s);
    end
    n_tests++;
    if (req_cnt_s != 64 || val_cnt_s != 0) begin
      n_fail++; $display("FAIL exhaust_counts: got %0d reqs %0d valido required 64 0", req_cnt_s, val_cnt_s);
    end
    n_tests++;
    if (nonce_valido_out_s !== 32'h0) begin
      n_fail++; $display("FAIL exhaust_nonce: got %h required 0", nonce_valido_out_s);
    end
  endtask

  task automatic test_four_hits();
    clear_mon();
    target = 8'h10; num_entradas = 2'd0;
    pulse_inicio();
    wait_fin("four_hits", 2000);
    n_tests++;
    if (vq_nonce.size() != 4) begin
      n_fail++; $display("FAIL four_hits_count: got %0d required 4", vq_nonce.size());
    end else begin
      n_tests++;
      if (vq_nonce[3] !== 32'hA3 || vq_bounty[3] !== 24'h061234 || vq_nonce[0] !== 32'hA0) begin
        n_fail++; $display("FAIL four_hits_values: got %h/%h first %h required a3/061234 first a0",
          vq_nonce[3], vq_bounty[3], vq_nonce[0]);
      end
    end
    n_tests++;
    if (agotado !== 1'b0) begin n_fail++; $display("FAIL four_hits_agotado: got %b required 0", agotado); end
  endtask

  task automatic test_reset_abort();
    int k = 0;
    target = 8'h10; num_entradas = 2'd2;
    pulse_inicio();
    while (!(hash_req && hash_nonce == 32'h5) && k < 100) begin @(negedge clk); k++; end
    n_tests++;
    if (!(hash_req && hash_nonce == 32'h5)) begin
      n_fail++; $display("FAIL abort_reach_n5: nonce=%h required 5", hash_nonce);
    end
    @(negedge clk);
    #2 reset_L = 1'b0;
    #1;
    n_tests++;
    if ({hash_req, hash_nonce, nonce_valido_out, bounty_out, valido, fin, agotado} !== '0) begin
      n_fail++; $display("FAIL abort_async_clear: nonce=%h nv=%h b=%h fin=%b required all 0",
        hash_nonce, nonce_valido_out, bounty_out, fin);
    end
    @(negedge clk);
    reset_L = 1'b1;
    clear_mon();
    repeat (8) @(negedge clk);
    n_tests++;
    if (req_cnt != 0 || vq_nonce.size() != 0 || fin !== 1'b0) begin
      n_fail++; $display("FAIL abort_late_valid: reqs=%0d valido=%0d fin=%b required 0 0 0",
        req_cnt, vq_nonce.size(), fin);
    end
    pulse_inicio();
    k = 0;
    while (!hash_req && k < 10) begin @(negedge clk); k++; end
    n_tests++;
    if (hash_req !== 1'b1 || hash_nonce !== 32'h0) begin
      n_fail++; $display("FAIL abort_restart: req=%b nonce=%h required 1 0", hash_req, hash_nonce);
    end
    do_reset();
  endtask

  task automatic test_ignore_inicio();
    int k = 0;
    clear_mon();
    target = 8'h10; num_entradas = 2'd2;
    pulse_inicio();
    while (!hash_req && k < 10) begin @(negedge clk); k++; end
    @(negedge clk);
    inicio = 1'b1; target = 8'hFF; num_entradas = 2'd1;
    @(negedge clk);
    inicio = 1'b0;
    wait_fin("ignore_inicio", 2000);
    n_tests++;
    if (vq_nonce.size() != 2 || req_cnt != 162) begin
      n_fail++; $display("FAIL ignore_counts: got %0d valido %0d reqs required 2 162", vq_nonce.size(), req_cnt);
    end else begin
      n_tests++;
      if (vq_nonce[0] !== 32'hA0 || vq_nonce[1] !== 32'hA1 || vq_bounty[1] !== 24'h041234) begin
        n_fail++; $display("FAIL ignore_values: got %h %h/%h required a0 a1/041234",
          vq_nonce[0], vq_nonce[1], vq_bounty[1]);
      end
    end
    n_tests++;
    if (agotado !== 1'b0) begin n_fail++; $display("FAIL ignore_agotado: got %b required 0", agotado); end
  endtask

  task automatic test_immediate_hit_restart();
    int k = 0;
    clear_mon();
    target = 8'hFF; num_entradas = 2'd1;
    pulse_inicio();
    while (!hash_valid && k < 20) begin @(negedge clk); k++; end
    @(negedge clk);
    n_tests++;
    if (fin !== 1'b0) begin n_fail++; $display("FAIL imm_fin_early: got %b required 0", fin); end
    @(negedge clk);
    n_tests++;
    if (fin !== 1'b1 || agotado !== 1'b0 || valido !== 1'b1 ||
        nonce_valido_out !== 32'h0 || bounty_out !== 24'hA51234) begin
      n_fail++; $display("FAIL imm_fin: fin=%b ag=%b v=%b nv=%h b=%h required 1 0 1 0 a51234",
        fin, agotado, valido, nonce_valido_out, bounty_out);
    end
    pulse_inicio();
    n_tests++;
    if (fin !== 1'b0 || hash_req !== 1'b1 || hash_nonce !== 32'h0) begin
      n_fail++; $display("FAIL imm_restart: fin=%b req=%b nonce=%h required 0 1 0", fin, hash_req, hash_nonce);
    end
    clear_mon();
    wait_fin("imm_repeat", 50);
    n_tests++;
    if (vq_nonce.size() != 1 || agotado !== 1'b0) begin
      n_fail++; $display("FAIL imm_repeat: got %0d valido agotado=%b required 1 0", vq_nonce.size(), agotado);
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_two_hits();
    test_exhaustion();
    test_four_hits();
    test_reset_abort();
    test_ignore_inicio();
    test_immediate_hit_restart();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
